// File: rtl/alu_operand_stage.sv
// ID/EX operand stage feeding the ALU.
// Holds one decoded instruction behind a valid/ready handshake, resolves
// EX/MEM and MEM/WB forwarding on the held source registers, and drives the
// ALU operands. While stalled, the held register values are refreshed from the
// forwarding paths every cycle, so a producer that retires during the stall
// is not lost.
`timescale 1ns/1ps

module alu_operand_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int REG_ADDR      = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,

  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    in_rs1_data,
  input  logic [DATA_WIDTH-1:0]    in_rs2_data,
  input  logic [DATA_WIDTH-1:0]    in_imm,
  input  logic [DATA_WIDTH-1:0]    in_pc,
  input  logic [REG_ADDR-1:0]      in_rs1,
  input  logic [REG_ADDR-1:0]      in_rs2,
  input  logic [REG_ADDR-1:0]      in_rd,
  input  logic                     in_reg_write,
  input  logic                     in_a_sel_pc,
  input  logic                     in_b_sel_imm,
  input  logic [OPCODE_LENGTH-1:0] in_operation,

  input  logic [REG_ADDR-1:0]      exmem_rd,
  input  logic                     exmem_reg_write,
  input  logic [DATA_WIDTH-1:0]    exmem_result,
  input  logic [REG_ADDR-1:0]      memwb_rd,
  input  logic                     memwb_reg_write,
  input  logic [DATA_WIDTH-1:0]    memwb_result,

  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic [REG_ADDR-1:0]      out_rd,
  output logic                     out_reg_write,
  output logic [DATA_WIDTH-1:0]    out_rs2_fwd,
  output logic [31:0]              stall_count
);

  // Everything the stage remembers about the held instruction.
  typedef struct packed {
    logic [DATA_WIDTH-1:0]    rs1_data;
    logic [DATA_WIDTH-1:0]    rs2_data;
    logic [DATA_WIDTH-1:0]    imm;
    logic [DATA_WIDTH-1:0]    pc;
    logic [REG_ADDR-1:0]      rs1;
    logic [REG_ADDR-1:0]      rs2;
    logic [REG_ADDR-1:0]      rd;
    logic                     reg_write;
    logic                     a_sel_pc;
    logic                     b_sel_imm;
    logic [OPCODE_LENGTH-1:0] operation;
  } instr_t;

  instr_t                  instr_q;
  logic                    valid_q;
  logic [31:0]             stall_q;
  logic [DATA_WIDTH-1:0]   fwd_rs1;
  logic [DATA_WIDTH-1:0]   fwd_rs2;
  logic                    load;
  logic                    hold;

  assign in_ready = !valid_q || out_ready;
  assign load     = in_valid && in_ready && !flush;
  assign hold     = valid_q && !out_ready && !flush;

  // Forwarding mux: EX/MEM beats MEM/WB; x0 is never forwarded.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    fwd_rs1 = instr_q.rs1_data;
    fwd_rs2 = instr_q.rs2_data;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == instr_q.rs1))
      fwd_rs1 = exmem_result;
    else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == instr_q.rs1))
      fwd_rs1 = memwb_result;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == instr_q.rs2))
      fwd_rs2 = exmem_result;
    else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == instr_q.rs2))
      fwd_rs2 = memwb_result;
  end

  // ALU-facing outputs, forced to zero whenever nothing valid is held.
  always_comb begin
    SrcA          = '0;
    SrcB          = '0;
    Operation     = '0;
    out_rd        = '0;
    out_reg_write = 1'b0;
    out_rs2_fwd   = '0;
    if (valid_q) begin
      SrcA          = instr_q.a_sel_pc  ? instr_q.pc  : fwd_rs1;
      SrcB          = instr_q.b_sel_imm ? instr_q.imm : fwd_rs2;
      Operation     = instr_q.operation;
      out_rd        = instr_q.rd;
      out_reg_write = instr_q.reg_write;
      out_rs2_fwd   = fwd_rs2;
    end
  end

  assign out_valid   = valid_q;
  assign stall_count = stall_q;

  // Instruction register: flush kills, load captures, hold refreshes sources.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples its pre-edge value, independent of statement order.
      valid_q <= 1'b0;
      instr_q <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q            <= 1'b1;
      instr_q.rs1_data   <= in_rs1_data;
      instr_q.rs2_data   <= in_rs2_data;
      instr_q.imm        <= in_imm;
      instr_q.pc         <= in_pc;
      instr_q.rs1        <= in_rs1;
      instr_q.rs2        <= in_rs2;
      instr_q.rd         <= in_rd;
      instr_q.reg_write  <= in_reg_write;
      instr_q.a_sel_pc   <= in_a_sel_pc;
      instr_q.b_sel_imm  <= in_b_sel_imm;
      instr_q.operation  <= in_operation;
    end else if (hold) begin
      instr_q.rs1_data <= fwd_rs1;
      instr_q.rs2_data <= fwd_rs2;
    end else if (valid_q && out_ready) begin
      valid_q <= 1'b0;
    end
  end

  // Saturating stall counter; only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_q <= '0;
    else if (hold && (stall_q != 32'hFFFF_FFFF))
      stall_q <= stall_q + 32'd1;
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed vectors, expected ALU-side responses
// queued by the stimulus and compared by an independent monitor on consume.
`timescale 1ns/1ps

module tb_alu_operand_stage;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm, in_pc;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_reg_write, in_a_sel_pc, in_b_sel_imm;
  logic [3:0]  in_operation;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        exmem_reg_write, memwb_reg_write;
  logic [31:0] exmem_result, memwb_result;
  logic        out_valid, out_ready;
  logic [31:0] SrcA, SrcB, out_rs2_fwd, stall_count;
  logic [3:0]  Operation;
  logic [4:0]  out_rd;
  logic        out_reg_write;

  alu_operand_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_pc(in_pc),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_reg_write(in_reg_write), .in_a_sel_pc(in_a_sel_pc),
    .in_b_sel_imm(in_b_sel_imm), .in_operation(in_operation),
    .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
    .out_rd(out_rd), .out_reg_write(out_reg_write),
    .out_rs2_fwd(out_rs2_fwd), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] srca;
    logic [31:0] srcb;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] rs2f;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Inputs change 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] rs1d, input logic [31:0] rs2d,
                       input logic [31:0] imm, input logic [31:0] pc,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic rw, input logic asel, input logic bsel,
                       input logic [3:0] op);
    in_valid     = 1'b1;
    in_rs1_data  = rs1d;
    in_rs2_data  = rs2d;
    in_imm       = imm;
    in_pc        = pc;
    in_rs1       = rs1;
    in_rs2       = rs2;
    in_rd        = rd;
    in_reg_write = rw;
    in_a_sel_pc  = asel;
    in_b_sel_imm = bsel;
    in_operation = op;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                            input logic [4:0] rd, input logic rw, input logic [31:0] r2);
    exp_t e;
    e.srca = a; e.srcb = b; e.op = op; e.rd = rd; e.rw = rw; e.rs2f = r2;
    sb.push_back(e);
  endtask

  // Monitor: every consumed output is compared against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_output", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("sb_SrcA",          SrcA,          e.srca);
          check("sb_SrcB",          SrcB,          e.srcb);
          check("sb_Operation",     Operation,     e.op);
          check("sb_out_rd",        out_rd,        e.rd);
          check("sb_out_reg_write", out_reg_write, e.rw);
          check("sb_out_rs2_fwd",   out_rs2_fwd,   e.rs2f);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; in_rs1_data = '0; in_rs2_data = '0; in_imm = '0; in_pc = '0;
    in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_reg_write = 1'b0;
    in_a_sel_pc = 1'b0; in_b_sel_imm = 1'b0; in_operation = '0;
    exmem_rd = '0; exmem_reg_write = 1'b0; exmem_result = '0;
    memwb_rd = '0; memwb_reg_write = 1'b0; memwb_result = '0;

    // Reset state
    #2;
    check("rst_out_valid",   out_valid,   0);
    check("rst_in_ready",    in_ready,    1);
    check("rst_SrcA",        SrcA,        0);
    check("rst_SrcB",        SrcB,        0);
    check("rst_Operation",   Operation,   0);
    check("rst_stall_count", stall_count, 0);
    step();
    reset = 1'b1;
    step();

    // Basic load: rs1=5, rs2=7, op=2
    expect_out(32'd5, 32'd7, 4'd2, 5'd3, 1'b1, 32'd7);
    drive(32'd5, 32'd7, 32'd0, 32'd0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 4'd2);
    step();
    idle();
    step();

    // Back-to-back with PC/imm selects, zero bubble
    expect_out(32'h100, 32'h20, 4'd0, 5'd4, 1'b1, 32'h66);
    drive(32'h99, 32'h66, 32'h20, 32'h100, 5'd7, 5'd8, 5'd4, 1'b1, 1'b1, 1'b1, 4'd0);
    step();
    expect_out(32'h11, 32'h22, 4'd5, 5'd9, 1'b0, 32'h22);
    drive(32'h11, 32'h22, 32'd0, 32'd0, 5'd10, 5'd11, 5'd9, 1'b0, 1'b0, 1'b0, 4'd5);
    mid();
    check("b2b_in_ready", in_ready, 1);
    step();
    idle();
    step();

    // Three-cycle stall; MEM/WB x2=0x55 only in the first stall cycle
    out_ready = 1'b0;
    drive(32'hA, 32'h10, 32'd0, 32'd0, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 4'd3);
    step();
    idle();
    memwb_rd = 5'd2; memwb_reg_write = 1'b1; memwb_result = 32'h55;
    mid();
    check("stall_c1_SrcB",    SrcB,     32'h55);
    check("stall_c1_in_ready", in_ready, 0);
    step();
    memwb_reg_write = 1'b0;
    mid();
    check("stall_c2_SrcB", SrcB, 32'h55);
    step();
    mid();
    check("stall_c3_SrcB", SrcB, 32'h55);
    step();
    out_ready = 1'b1;
    expect_out(32'hA, 32'h55, 4'd3, 5'd7, 1'b1, 32'h55);
    mid();
    check("stall_count_3", stall_count, 3);
    step();

    // Held x3: EX/MEM 9 beats MEM/WB 4; then MEM/WB alone
    out_ready = 1'b0;
    drive(32'd1, 32'd2, 32'd0, 32'd0, 5'd3, 5'd4, 5'd6, 1'b1, 1'b0, 1'b0, 4'd1);
    step();
    idle();
    exmem_rd = 5'd3; exmem_reg_write = 1'b1; exmem_result = 32'd9;
    memwb_rd = 5'd3; memwb_reg_write = 1'b1; memwb_result = 32'd4;
    mid();
    check("fwd_exmem_prio_SrcA", SrcA, 32'd9);
    step();
    exmem_reg_write = 1'b0;
    mid();
    check("fwd_memwb_SrcA", SrcA, 32'd4);
    step();
    memwb_reg_write = 1'b0;
    out_ready = 1'b1;
    expect_out(32'd4, 32'd2, 4'd1, 5'd6, 1'b1, 32'd2);
    mid();
    check("stall_count_5", stall_count, 5);
    step();

    // x0 never forwarded
    exmem_rd = 5'd0; exmem_reg_write = 1'b1; exmem_result = 32'hDEAD;
    expect_out(32'd0, 32'd0, 4'd6, 5'd1, 1'b1, 32'd0);
    drive(32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, 4'd6);
    step();
    idle();
    step();

    // rs2 forwarded with imm selected for SrcB: store data still forwarded
    exmem_rd = 5'd5; exmem_reg_write = 1'b1; exmem_result = 32'h77;
    memwb_rd = 5'd5; memwb_reg_write = 1'b1; memwb_result = 32'h88;
    expect_out(32'd3, 32'd8, 4'd7, 5'd2, 1'b0, 32'h77);
    drive(32'd3, 32'h33, 32'd8, 32'd0, 5'd6, 5'd5, 5'd2, 1'b0, 1'b0, 1'b1, 4'd7);
    step();
    idle();
    step();
    exmem_reg_write = 1'b0;
    memwb_reg_write = 1'b0;

    // Flush while holding, then flush against a load that would be accepted
    out_ready = 1'b0;
    drive(32'd1, 32'd1, 32'd0, 32'd0, 5'd1, 5'd1, 5'd1, 1'b1, 1'b0, 1'b0, 4'd1);
    step();
    drive(32'hBB, 32'hBB, 32'd0, 32'd0, 5'd2, 5'd2, 5'd2, 1'b1, 1'b0, 1'b0, 4'd9);
    flush = 1'b1;
    step();
    mid();
    check("flush_hold_out_valid", out_valid, 0);
    step();
    mid();
    check("flush_over_load_out_valid", out_valid, 0);
    flush = 1'b0;
    idle();
    step();
    mid();
    check("post_flush_out_valid", out_valid, 0);
    check("flush_stall_count",    stall_count, 5);

    // Reset asserted mid-hold
    drive(32'h12, 32'h34, 32'd0, 32'd0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 4'd2);
    step();
    idle();
    step();
    mid();
    check("prereset_out_valid",   out_valid,   1);
    check("prereset_stall_count", stall_count, 6);
    #1;
    reset = 1'b0;
    #1;
    check("arst_out_valid",   out_valid,   0);
    check("arst_SrcA",        SrcA,        0);
    check("arst_SrcB",        SrcB,        0);
    check("arst_stall_count", stall_count, 0);
    check("arst_in_ready",    in_ready,    1);
    step();
    reset = 1'b1;
    out_ready = 1'b1;
    step();

    // Every expected response must have been consumed
    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    check("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
